// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: source end of a four-phase req/ack pulse-transfer channel.
// Single-cycle pulses become level requests that a slower receiver can sample.
// Pulses arriving mid-handshake are queued in a saturating counter and sent
// back-to-back. ack_in is asynchronous and passes through a flop chain first.
module pulse_handshake_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             sent,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic                   inc, dec, sat, overflow_c;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous acknowledge level
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    // Next-state, queue increment/decrement and request level decode
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                // ack_sync deliberately ignored here: a spurious ack does nothing
                if (pulse_in) state_d = REQ;
            end
            REQ: begin
                inc = pulse_in;
                if (ack_sync) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (ack_sync) begin
                    inc = pulse_in;
                end else if (pending_q != '0) begin
                    // Queued pulse launches; a coincident new pulse takes its
                    // slot in the queue, so the count only drops without one.
                    state_d = REQ;
                    dec     = ~pulse_in;
                end else if (pulse_in) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sat        = (pending_q == '1);
        overflow_c = inc & sat;

        pending_d = pending_q;
        if (inc && !sat) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (dec) begin
            pending_d = pending_q - CNT_W'(1);
        end

        req_d = (state_d == REQ);
    end

    // FSM, request level and pending-pulse counter registers
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
        end
    end

    // Strobes are decoded from registers (and pulse_in), never from raw ack_in
    assign sent     = ~rst & (state_q == REQ) & ack_sync;
    assign overflow = ~rst & overflow_c;
    assign req_out  = req_q;
    assign pending  = pending_q;
    assign busy     = (state_q != IDLE) | (pending_q != '0);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx: a vector table for the cycle-exact
// sequences plus looped sequences for burst queueing and counter saturation.
module tb_pulse_handshake_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       p, a, p2, a2;
    logic       req, busy, snt, ovf;
    logic [3:0] pnd;
    logic       req2, busy2, snt2, ovf2;
    logic [1:0] pnd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk_fast(clk), .rst(rst), .pulse_in(p), .ack_in(a),
        .req_out(req), .busy(busy), .pending(pnd), .sent(snt), .overflow(ovf)
    );

    pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk_fast(clk), .rst(rst), .pulse_in(p2), .ack_in(a2),
        .req_out(req2), .busy(busy2), .pending(pnd2), .sent(snt2), .overflow(ovf2)
    );

    typedef struct {
        logic       r, p, a;
        logic       req, snt, bsy;
        logic [3:0] pnd;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r_i, input logic p_i, input logic a_i,
                       input logic rq, input logic s, input logic b,
                       input logic [3:0] pn, input logic o);
        vec_t v;
        v.r = r_i; v.p = p_i; v.a = a_i;
        v.req = rq; v.snt = s; v.bsy = b; v.pnd = pn; v.ovf = o;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    initial begin
        int rises, sents, maxp, ovfs;
        logic prev;
        logic [2:0] h;
        int exp_p2[8];

        // Reset state
        add(0,0,0, 0,0,0,0,0);
        // Single pulse, receiver echoes after 3 cycles (cycles 0..13)
        add(0,1,0, 0,0,0,0,0);
        add(0,0,0, 1,0,1,0,0);
        add(0,0,0, 1,0,1,0,0);
        add(0,0,0, 1,0,1,0,0);
        add(0,0,1, 1,0,1,0,0);
        add(0,0,1, 1,0,1,0,0);
        add(0,0,1, 1,1,1,0,0);
        add(0,0,1, 0,0,1,0,0);
        add(0,0,1, 0,0,1,0,0);
        add(0,0,1, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0,0,0);
        // Pulse coincident with WAIT_LOW->REQ, pending = 0
        add(0,1,0, 0,0,0,0,0);
        add(0,0,1, 1,0,1,0,0);
        add(0,0,1, 1,0,1,0,0);
        add(0,0,1, 1,1,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(0,1,0, 0,0,1,0,0);
        add(0,0,0, 1,0,1,0,0);
        // Queue two pulses, then coincident pulse with pending = 2
        add(0,1,1, 1,0,1,0,0);
        add(0,1,1, 1,0,1,1,0);
        add(0,0,1, 1,1,1,2,0);
        add(0,0,0, 0,0,1,2,0);
        add(0,0,0, 0,0,1,2,0);
        add(0,1,1, 0,0,1,2,0);
        add(0,1,1, 1,0,1,2,0);
        // Reset with req_out=1, pending=3 and ack_sync high
        add(1,0,0, 1,0,1,3,0);
        add(0,0,0, 0,0,0,0,0);
        // Spurious ack while idle
        add(0,0,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);

        rst = 1'b1; p = 1'b0; a = 1'b0; p2 = 1'b0; a2 = 1'b0;
        repeat (3) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; p = tbl[i].p; a = tbl[i].a;
            #1;
            check($sformatf("row%0d req_out", i),  req,  tbl[i].req);
            check($sformatf("row%0d sent", i),     snt,  tbl[i].snt);
            check($sformatf("row%0d busy", i),     busy, tbl[i].bsy);
            check($sformatf("row%0d pending", i),  pnd,  tbl[i].pnd);
            check($sformatf("row%0d overflow", i), ovf,  tbl[i].ovf);
        end

        // Burst of 5 pulses with a 3-cycle echoing receiver
        rises = 0; sents = 0; maxp = 0; ovfs = 0; prev = 1'b0; h = '0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            p = (k < 5);
            a = h[2];
            #1;
            if (req && !prev) rises++;
            if (snt) sents++;
            if (ovf) ovfs++;
            if (int'(pnd) > maxp) maxp = int'(pnd);
            if (k == 5) check("burst pending@5", pnd, 4);
            prev = req;
            h = {h[1:0], req};
        end
        check("burst req rises", rises, 5);
        check("burst sent count", sents, 5);
        check("burst max pending", maxp, 4);
        check("burst overflow count", ovfs, 0);
        check("burst final pending", pnd, 0);
        check("burst final busy", busy, 0);

        // CNT_W=2, stalled receiver, 6 pulses
        exp_p2 = '{0, 0, 1, 2, 3, 3, 3, 3};
        p = 1'b0; a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            p2 = (k < 6);
            a2 = 1'b0;
            #1;
            check($sformatf("stall pending@%0d", k), pnd2, exp_p2[k]);
            check($sformatf("stall overflow@%0d", k), ovf2, (k == 4 || k == 5) ? 1 : 0);
            check($sformatf("stall req@%0d", k), req2, (k >= 1) ? 1 : 0);
        end
        sents = 0; ovfs = 0; h = '0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            p2 = 1'b0;
            a2 = h[2];
            #1;
            if (snt2) sents++;
            if (ovf2) ovfs++;
            h = {h[1:0], req2};
        end
        check("stall sent count", sents, 4);
        check("stall late overflow", ovfs, 0);
        check("stall final pending", pnd2, 0);
        check("stall final busy", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
